// File: rtl/sram_scheduler.sv
// Arbitrates the single-port SRAM frame store between display line prefetch,
// camera pixel read-modify-write and full-frame erase.
module sram_scheduler #(
  parameter int H_VISIBLE      = 640,
  parameter int V_VISIBLE      = 480,
  parameter int WORDS_PER_LINE = 40,
  parameter int FRAME_WORDS    = 19200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcounter,
  input  logic [9:0]  vcounter,
  input  logic        cam_valid,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        erase_req,
  output logic [17:0] address,
  output logic [15:0] data_write,
  output logic        read,
  output logic        write,
  input  logic        ready,
  input  logic [15:0] data_read,
  output logic        lb_wr_en,
  output logic [5:0]  lb_wr_addr,
  output logic [15:0] lb_wr_data,
  output logic        busy,
  output logic        fill_overrun
);

  localparam logic [10:0] H_END      = H_VISIBLE[10:0];
  localparam logic [9:0]  V_END      = V_VISIBLE[9:0];
  localparam logic [9:0]  V_LAST     = V_END - 10'd1;
  localparam logic [5:0]  LAST_WORD  = 6'(WORDS_PER_LINE - 1);
  localparam logic [17:0] WPL        = 18'(WORDS_PER_LINE);
  localparam logic [14:0] ERASE_LAST = 15'(FRAME_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, FILL_RD, FILL_WAIT, CAM_RD, CAM_RWAIT, CAM_WR, CAM_WWAIT, ERASE_WR, ERASE_WAIT
  } state_t;

  state_t      state;
  logic        trig_prev, vblank_prev;
  logic        fill_pend, cam_pend, erase_pend, erase_active;
  logic [9:0]  fill_line;
  logic [5:0]  idx;
  logic [14:0] eidx;
  logic [9:0]  cam_x, cam_y;
  logic [3:0]  cam_bit;

  logic        trig_cond, trig_edge, vblank_cond, vblank_edge, filling, cam_in_range;
  logic [9:0]  next_line;

  assign trig_cond    = (hcounter == H_END) && (vcounter < V_END);
  assign trig_edge    = trig_cond && !trig_prev;
  assign vblank_cond  = (vcounter == V_END);
  assign vblank_edge  = vblank_cond && !vblank_prev;
  assign next_line    = (vcounter == V_LAST) ? 10'd0 : vcounter + 10'd1;
  assign filling      = (state == FILL_RD) || (state == FILL_WAIT);
  assign cam_in_range = ({1'b0, x} < H_END) && (y < V_END);

  // Job sequencing; request latching comes after the case so that a new
  // request in the same cycle as a completion is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      address      <= '0;
      data_write   <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      lb_wr_en     <= 1'b0;
      lb_wr_addr   <= '0;
      lb_wr_data   <= '0;
      busy         <= 1'b0;
      fill_overrun <= 1'b0;
      trig_prev    <= 1'b0;
      vblank_prev  <= 1'b0;
      fill_pend    <= 1'b0;
      cam_pend     <= 1'b0;
      erase_pend   <= 1'b0;
      erase_active <= 1'b0;
      fill_line    <= '0;
      idx          <= '0;
      eidx         <= '0;
      cam_x        <= '0;
      cam_y        <= '0;
      cam_bit      <= '0;
    end else begin
      lb_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_pend) begin
            fill_pend <= 1'b0;
            idx       <= '0;
            state     <= FILL_RD;
            busy      <= 1'b1;
          end else if (erase_active) begin
            state <= ERASE_WR;
            busy  <= 1'b1;
          end else if (cam_pend) begin
            state <= CAM_RD;
            busy  <= 1'b1;
          end
        end
        FILL_RD: begin
          address <= {8'd0, fill_line} * WPL + {12'd0, idx};
          read    <= 1'b1;
          state   <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (ready) begin
            read       <= 1'b0;
            lb_wr_en   <= 1'b1;
            lb_wr_addr <= idx;
            lb_wr_data <= data_read;
            if (idx == LAST_WORD) begin
              idx   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + 6'd1;
              state <= FILL_RD;
            end
          end
        end
        // The bit position is captured here so a newer camera point cannot
        // disturb the write half of this read-modify-write.
        CAM_RD: begin
          address <= {8'd0, cam_y} * WPL + {12'd0, cam_x[9:4]};
          cam_bit <= 4'd15 - cam_x[3:0];
          read    <= 1'b1;
          state   <= CAM_RWAIT;
        end
        CAM_RWAIT: begin
          if (ready) begin
            read       <= 1'b0;
            data_write <= data_read | (16'd1 << cam_bit);
            state      <= CAM_WR;
          end
        end
        CAM_WR: begin
          write <= 1'b1;
          state <= CAM_WWAIT;
        end
        CAM_WWAIT: begin
          if (ready) begin
            write    <= 1'b0;
            cam_pend <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
        ERASE_WR: begin
          address    <= {3'd0, eidx};
          data_write <= '0;
          write      <= 1'b1;
          state      <= ERASE_WAIT;
        end
        ERASE_WAIT: begin
          if (ready) begin
            write <= 1'b0;
            state <= IDLE;
            busy  <= 1'b0;
            if (eidx == ERASE_LAST) begin
              eidx         <= '0;
              erase_active <= 1'b0;
              erase_pend   <= 1'b0;
            end else begin
              eidx <= eidx + 15'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          read  <= 1'b0;
          write <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      trig_prev   <= trig_cond;
      vblank_prev <= vblank_cond;
      if (trig_edge) begin
        if (filling) begin
          fill_overrun <= 1'b1;
        end else begin
          fill_pend <= 1'b1;
          fill_line <= next_line;
        end
      end
      if (vblank_edge && erase_pend && !erase_active)
        erase_active <= 1'b1;
      if (erase_req)
        erase_pend <= 1'b1;
      if (cam_valid && cam_in_range) begin
        cam_x    <= x;
        cam_y    <= y;
        cam_pend <= 1'b1;
      end
    end
  end

endmodule
